// File: rtl/somador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/SomadorCompleto.sv
// One-bit full adder cell used by the serial adder datapath.
module SomadorCompleto (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic R,
    output logic Cout
);

    assign R    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder: one full-adder cell, registered carry, result after N cycles.
// Optional macro SOMADOR_SERIAL_SUB_EN adds a Sub input for A - B - Cin.
import somador_pkg::*;

module somador_serial #(
    parameter int N = DEFAULT_N
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
`ifdef SOMADOR_SERIAL_SUB_EN
    input  logic         Sub,
`endif
    output logic [N-1:0] R,
    output logic         Cout,
    output logic         Overflow,
    output logic         Busy,
    output logic         Done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [N-1:0]   sa_q, sa_d, sb_q, sb_d, r_q, r_d;
    logic [N-2:0]   ps_q, ps_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic           cellSum, cellCout, load;
    logic [N-1:0]   loadB, fullSum;
    logic           loadCin;

    // Subtraction is folded into the load: invert B and the initial carry once.
`ifdef SOMADOR_SERIAL_SUB_EN
    assign loadB   = Sub ? ~B : B;
    assign loadCin = Sub ? ~Cin : Cin;
`else
    assign loadB   = B;
    assign loadCin = Cin;
`endif

    SomadorCompleto u_cell (
        .A    (sa_q[0]),
        .B    (sb_q[0]),
        .Cin  (carry_q),
        .R    (cellSum),
        .Cout (cellCout)
    );

    assign load    = Start && (state_q == IDLE || state_q == DONE);
    assign fullSum = {cellSum, ps_q};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        r_d     = r_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: state_d = IDLE;
            SHIFT: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                ps_d    = fullSum[N-1:1];
                carry_d = cellCout;
                cnt_d   = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB, so overflow is its XOR with carry out
                if (cnt_q == CW'(N - 1)) begin
                    r_d     = fullSum;
                    cout_d  = cellCout;
                    ovf_d   = carry_q ^ cellCout;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            sa_d    = A;
            sb_d    = loadB;
            carry_d = loadCin;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign R        = r_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;
    assign Busy     = (state_q == SHIFT);
    assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_somador_serial.sv
// Scoreboard bench for somador_serial: directed cases plus random operands vs an arithmetic model.
module tb_somador_serial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin, sub;
    logic [N-1:0] a, b;
    logic [N-1:0] r;
    logic         cout, ovf, busy, done;

    typedef struct {
        logic [N-1:0] r;
        logic         cout;
        logic         ovf;
        int           cycle;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    int           cycle  = 0;
    logic [N-1:0] lastR;
    logic         lastCout, lastOvf;

    somador_serial #(.N(N)) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (start),
        .A        (a),
        .B        (b),
        .Cin      (cin),
`ifdef SOMADOR_SERIAL_SUB_EN
        .Sub      (sub),
`endif
        .R        (r),
        .Cout     (cout),
        .Overflow (ovf),
        .Busy     (busy),
        .Done     (done)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to check the start-to-done latency.
    always @(posedge clk) cycle <= cycle + 1;

    // Expected result from plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib,
                                   input logic icin, input logic isub, input int doneCycle);
        exp_t         e;
        logic [N:0]   s;
        logic [N-1:0] be;
        logic         ce;
        be = isub ? ~ib : ib;
        ce = isub ? ~icin : icin;
        s = {1'b0, ia} + {1'b0, be} + {{N{1'b0}}, ce};
        e.r     = s[N-1:0];
        e.cout  = s[N];
        e.ovf   = (ia[N-1] == be[N-1]) && (s[N-1] != ia[N-1]);
        e.cycle = doneCycle;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on Done, otherwise verifies the result registers hold.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rst) begin
            checkOutput("resetState", {r, cout, ovf, busy, done}, '0);
            lastR = '0; lastCout = 1'b0; lastOvf = 1'b0;
        end else if (done) begin
            checkOutput("busyInDone", busy, 1'b0);
            if (sbq.size() == 0) begin
                checkOutput("unexpectedDone", 1, 0);
            end else begin
                e = sbq.pop_front();
                checkOutput("resultR", r, e.r);
                checkOutput("resultCout", cout, e.cout);
                checkOutput("resultOverflow", ovf, e.ovf);
                checkOutput("doneLatency", cycle, e.cycle);
                lastR = e.r; lastCout = e.cout; lastOvf = e.ovf;
            end
        end else begin
            checkOutput("resultHold", {r, cout, ovf}, {lastR, lastCout, lastOvf});
        end
    end

    // Waits for a cycle where Start is accepted (Busy low), drives it for one edge.
    task automatic applyStimulus(input logic [N-1:0] ia, input logic [N-1:0] ib,
                                 input logic icin, input logic isub);
        int waited = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            start = 1'b0;
            waited++;
            if (waited > 4 * N) begin
                checkOutput("startTimeout", 1, 0);
                return;
            end
        end
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        sbq.push_back(model(ia, ib, icin, isub, cycle + 1 + N));
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", busy, 1'b1);
    endtask

    task automatic idleCycles(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic applyReset(input int n);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        sbq.delete();
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idleCycles(2);

        applyStimulus(8'h3C, 8'h5A, 1'b0, 1'b0);
        idleCycles(N + 2);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
        idleCycles(N + 2);

        // Start pulsed mid-operation must be ignored.
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
        idleCycles(2);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idleCycles(N + 2);

        // Back-to-back: second Start lands in the DONE cycle.
        applyStimulus(8'h3C, 8'h5A, 1'b0, 1'b0);
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        idleCycles(N + 2);

        // Reset mid-SHIFT aborts with no Done afterwards.
        applyStimulus(8'hAB, 8'hCD, 1'b1, 1'b0);
        idleCycles(3);
        applyReset(1);
        idleCycles(20);

`ifdef SOMADOR_SERIAL_SUB_EN
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
        applyStimulus(8'h03, 8'h05, 1'b0, 1'b1);
        idleCycles(N + 2);
`endif

        for (int i = 0; i < 24; i++) begin
            logic isub;
`ifdef SOMADOR_SERIAL_SUB_EN
            isub = 1'($urandom_range(0, 1));
`else
            isub = 1'b0;
`endif
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), isub);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end

        waited = 0;
        while (sbq.size() != 0 && waited < 4 * N) begin
            @(negedge clk);
            waited++;
        end
        idleCycles(3);
        checkOutput("scoreboardDrained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
